// File: rtl/sva_chk_pkg.sv
// Shared types, limits and helpers for the range-sequence checker.
package sva_chk_pkg;

  typedef logic [31:0] age_vec_t;

  localparam int unsigned MAX_DLY_LIMIT = 31;

  // Saturating add on 32-bit containers; callers pass their own ceiling.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, lim}) return lim;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sva_chk_popcnt.sv
// Parameterized-width population count.
module sva_chk_popcnt #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt_c
);

  // Count set bits of vec.
  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt_c = cnt_c + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/sva_range_seq_checker.sv
// Monitor for (a ##[MIN_DLY:MAX_DLY] b) |-> c with concurrent attempts.
// Optional macro SVA_RANGE_SEQ_VACUOUS_EN adds a vacuous-retirement counter.
module sva_range_seq_checker
  import sva_chk_pkg::*;
#(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               a,
  input  logic               b,
  input  logic               c,
  output logic               fail,
  output logic [5:0]         fail_num,
  output logic               pass,
  output logic [CNT_W-1:0]   fail_count,
  output logic [MAX_DLY-1:0] active
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
  ,
  output logic [CNT_W-1:0]   vacuous_count
`endif
);

  localparam int unsigned NUM_W   = 6;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  generate
    if (MIN_DLY < 1 || MIN_DLY > MAX_DLY || MAX_DLY > MAX_DLY_LIMIT) begin : g_bad_param
      $error("sva_range_seq_checker: illegal MIN_DLY/MAX_DLY");
    end
  endgenerate

  // Bit k-1 of live_q/matched_q describes the attempt that is aged k at the next edge.
  logic [MAX_DLY-1:0] live_q, live_d;
  logic [MAX_DLY-1:0] matched_q, matched_d;
  logic [MAX_DLY-1:0] hit_c, fail_vec_c, survive_c, seen_c;
  logic               pass_c;
  logic [NUM_W-1:0]   fail_num_c;
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
  logic [0:0]         vac_c;
  logic [0:0]         vac_num_c;
`endif

  // Evaluate every live attempt against b/c, then age the survivors by one.
  always_comb begin
    hit_c      = '0;
    fail_vec_c = '0;
    survive_c  = '0;
    seen_c     = '0;
    live_d     = '0;
    matched_d  = '0;
    pass_c     = 1'b0;
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
    vac_c      = 1'b0;
`endif
    for (int unsigned k = 0; k < MAX_DLY; k++) begin
      hit_c[k]      = live_q[k] && b && ((k + 1) >= MIN_DLY);
      fail_vec_c[k] = hit_c[k] && !c;
      survive_c[k]  = live_q[k] && !fail_vec_c[k];
      seen_c[k]     = matched_q[k] || (hit_c[k] && c);
    end
    for (int unsigned k = 1; k < MAX_DLY; k++) begin
      live_d[k]    = survive_c[k-1];
      matched_d[k] = survive_c[k-1] && seen_c[k-1];
    end
    live_d[0] = en && a;
    pass_c    = survive_c[MAX_DLY-1] && seen_c[MAX_DLY-1];
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
    vac_c[0]  = survive_c[MAX_DLY-1] && !seen_c[MAX_DLY-1];
`endif
  end

  sva_chk_popcnt #(.W(MAX_DLY), .CW(NUM_W)) u_fail_pop (
    .vec   (fail_vec_c),
    .cnt_c (fail_num_c)
  );

`ifdef SVA_RANGE_SEQ_VACUOUS_EN
  sva_chk_popcnt #(.W(1), .CW(1)) u_vac_pop (
    .vec   (vac_c),
    .cnt_c (vac_num_c)
  );

  // Saturating count of attempts that retired without any match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vacuous_count <= '0;
    else     vacuous_count <= CNT_W'(sat_add(32'(vacuous_count), 32'(vac_num_c), CNT_MAX));
  end
`endif

  // Attempt state, result pulses and the saturating failure total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q     <= '0;
      matched_q  <= '0;
      fail       <= 1'b0;
      fail_num   <= '0;
      pass       <= 1'b0;
      fail_count <= '0;
    end else begin
      live_q     <= live_d;
      matched_q  <= matched_d;
      fail       <= |fail_vec_c;
      fail_num   <= fail_num_c;
      pass       <= pass_c;
      fail_count <= CNT_W'(sat_add(32'(fail_count), 32'(fail_num_c), CNT_MAX));
    end
  end

  assign active = live_q;

endmodule

// File: tb/tb_sva_range_seq_checker.sv
// Bench for sva_range_seq_checker: vector table, corner sequences, random vs model.
module tb_sva_range_seq_checker;

  logic clk = 1'b0;
  logic rst, en, a, b, c;

  logic       fail0, pass0, fail1, pass1;
  logic [5:0] num0, num1;
  logic [15:0] fc0;
  logic [1:0]  fc1;
  logic [2:0]  act0, act1;
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
  logic [15:0] vc0;
  logic [1:0]  vc1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  sva_range_seq_checker #(.MIN_DLY(1), .MAX_DLY(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .fail(fail0), .fail_num(num0), .pass(pass0), .fail_count(fc0), .active(act0)
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
    , .vacuous_count(vc0)
`endif
  );

  sva_range_seq_checker #(.MIN_DLY(2), .MAX_DLY(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .fail(fail1), .fail_num(num1), .pass(pass1), .fail_count(fc1), .active(act1)
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
    , .vacuous_count(vc1)
`endif
  );

  // Reference model: attempts stored by launch cycle, judged by their age.
  bit  m_live  [2][64];
  bit  m_match [2][64];
  int  m_launch[2][64];
  int  e_num [2];
  bit  e_fail[2];
  bit  e_pass[2];
  int  e_fc  [2];
  int  e_vc  [2];
  int  e_act [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 64; s++) begin
        m_live[m][s] = 0; m_match[m][s] = 0; m_launch[m][s] = 0;
      end
      e_num[m] = 0; e_fail[m] = 0; e_pass[m] = 0;
      e_fc[m] = 0; e_vc[m] = 0; e_act[m] = 0;
    end
  endtask

  task automatic model_edge(input int m, input int mn, input int mx, input int cmax);
    int nf, nv, age, slot;
    bit ps;
    nf = 0; nv = 0; ps = 0;
    for (int s = 0; s < 64; s++) begin
      if (m_live[m][s]) begin
        age = cyc - m_launch[m][s];
        if (age >= mn && age <= mx && b) begin
          if (!c) begin
            nf++;
            m_live[m][s] = 0;
          end else begin
            m_match[m][s] = 1;
          end
        end
        if (m_live[m][s] && age == mx) begin
          if (m_match[m][s]) ps = 1;
          else nv++;
          m_live[m][s] = 0;
        end
      end
    end
    if (en && a) begin
      slot = cyc % 64;
      m_live[m][slot] = 1; m_match[m][slot] = 0; m_launch[m][slot] = cyc;
    end
    e_num[m]  = nf;
    e_fail[m] = (nf > 0);
    e_pass[m] = ps;
    e_fc[m]   = (e_fc[m] + nf > cmax) ? cmax : e_fc[m] + nf;
    e_vc[m]   = (e_vc[m] + nv > cmax) ? cmax : e_vc[m] + nv;
    e_act[m]  = 0;
    for (int s = 0; s < 64; s++)
      if (m_live[m][s]) e_act[m] = e_act[m] | (1 << (cyc - m_launch[m][s]));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    chk("m0_fail",   32'(fail0), 32'(e_fail[0]));
    chk("m0_num",    32'(num0),  32'(e_num[0]));
    chk("m0_pass",   32'(pass0), 32'(e_pass[0]));
    chk("m0_fcount", 32'(fc0),   32'(e_fc[0]));
    chk("m0_active", 32'(act0),  32'(e_act[0]));
    chk("m1_fail",   32'(fail1), 32'(e_fail[1]));
    chk("m1_num",    32'(num1),  32'(e_num[1]));
    chk("m1_pass",   32'(pass1), 32'(e_pass[1]));
    chk("m1_fcount", 32'(fc1),   32'(e_fc[1]));
    chk("m1_active", 32'(act1),  32'(e_act[1]));
`ifdef SVA_RANGE_SEQ_VACUOUS_EN
    chk("m0_vac",    32'(vc0),   32'(e_vc[0]));
    chk("m1_vac",    32'(vc1),   32'(e_vc[1]));
`endif
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare after it.
  task automatic step(input bit ien, input bit ia, input bit ib, input bit ic, input bit irst);
    en = ien; a = ia; b = ib; c = ic; rst = irst;
    @(posedge clk);
    cyc++;
    if (irst) model_reset();
    else begin
      model_edge(0, 1, 3, 65535);
      model_edge(1, 2, 3, 3);
    end
    #1;
    check_all();
  endtask

  typedef struct {
    bit en, a, b, c;
    bit fail;
    int num;
    bit pass;
    int act;
    int fc;
  } vec_t;

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1,1,0,0, 0,0,0, 3'b001, 0};
    tbl[1]  = '{1,0,0,0, 0,0,0, 3'b010, 0};
    tbl[2]  = '{1,0,1,0, 1,1,0, 3'b000, 1};
    tbl[3]  = '{1,1,0,0, 0,0,0, 3'b001, 1};
    tbl[4]  = '{1,1,0,0, 0,0,0, 3'b011, 1};
    tbl[5]  = '{1,0,1,0, 1,2,0, 3'b000, 3};
    tbl[6]  = '{1,1,0,0, 0,0,0, 3'b001, 3};
    tbl[7]  = '{1,0,1,1, 0,0,0, 3'b010, 3};
    tbl[8]  = '{1,0,0,0, 0,0,0, 3'b100, 3};
    tbl[9]  = '{1,0,0,0, 0,0,1, 3'b000, 3};
    tbl[10] = '{1,1,0,0, 0,0,0, 3'b001, 3};
    tbl[11] = '{1,0,0,0, 0,0,0, 3'b010, 3};
    tbl[12] = '{1,0,0,0, 0,0,0, 3'b100, 3};
    tbl[13] = '{1,0,0,0, 0,0,0, 3'b000, 3};
    tbl[14] = '{1,0,1,0, 0,0,0, 3'b000, 3};
    tbl[15] = '{0,1,0,0, 0,0,0, 3'b000, 3};
    tbl[16] = '{1,0,1,0, 0,0,0, 3'b000, 3};
    tbl[17] = '{1,1,0,0, 0,0,0, 3'b001, 3};
    tbl[18] = '{1,0,1,1, 0,0,0, 3'b010, 3};
    tbl[19] = '{1,0,0,0, 0,0,0, 3'b100, 3};
    tbl[20] = '{1,0,1,0, 1,1,0, 3'b000, 4};

    en = 0; a = 0; b = 0; c = 0; rst = 1;
    model_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_fail",   32'(fail0), 32'd0);
    chk("reset_fcount", 32'(fc0),   32'd0);
    chk("reset_active", 32'(act0),  32'd0);

    // Vector table on the MIN=1/MAX=3 instance.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].c, 0);
      chk($sformatf("tbl%0d_fail", i),   32'(fail0), 32'(tbl[i].fail));
      chk($sformatf("tbl%0d_num", i),    32'(num0),  32'(tbl[i].num));
      chk($sformatf("tbl%0d_pass", i),   32'(pass0), 32'(tbl[i].pass));
      chk($sformatf("tbl%0d_active", i), 32'(act0),  32'(tbl[i].act));
      chk($sformatf("tbl%0d_fcount", i), 32'(fc0),   32'(tbl[i].fc));
      if (i == 9) chk("min2_age1_b_no_pass", 32'(pass1), 32'd0);
    end

    // Asynchronous reset between edges discards an in-flight attempt.
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("async_rst_active0", 32'(act0), 32'd0);
    chk("async_rst_active1", 32'(act1), 32'd0);
    model_reset();
    step(1, 0, 1, 0, 0);
    chk("after_rst_no_fail", 32'(fail0), 32'd0);

    // Four separate failing attempts: 16-bit counter reaches 4, 2-bit one holds at 3.
    step(0, 0, 0, 0, 1);
    for (int r = 0; r < 4; r++) begin
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
    end
    chk("sat_fcount_wide", 32'(fc0), 32'd4);
    chk("sat_fcount_cnt2", 32'(fc1), 32'd3);

    // Randomized traffic against the model, with occasional resets.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(9, 0) != 0, $urandom_range(9, 0) < 4,
           $urandom_range(9, 0) < 4,   $urandom_range(9, 0) < 6,
           $urandom_range(99, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
